load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit between the MEM pipeline stage and the data-memory bus. It accepts one access per handshake and builds byte enables and lane-replicated store data. It waits for a memory acknowledge with a timeout, then returns a sign- or zero-extended load result, or an exception code, as a one-cycle response. It generalises the combinational load extender to any 2^n-byte data width, adds stores, alignment checking and a bus FSM.

## Interface
- DATA_W, 32: memory/data width in bits; legal values are 32 or 64. NB = DATA_W/8 lanes; LB = log2(NB).
- ADDR_W, 32: byte address width.
- TIMEOUT, 16: maximum cycles to wait for mem_ack; 0 disables the timeout.

Ports (clk, reset first):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  access request.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- req_unsigned  in  1  zero-extend the load result (lbu/lhu/lwu); ignored for stores and full-width loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  req_addr with its low LB bits cleared.
- mem_be  out  NB  byte enables.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ack  in  1  bus acknowledge; sampled only while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and exceptions.
- rsp_exc  out  2  00 ok, 01 load address error, 10 store address error, 11 bus timeout.

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state==IDLE).
- IDLE, req_valid=1: latch the request.
  - Misaligned access (addr mod 2^size != 0) or size=3 with DATA_W=32: go to RESP with rsp_exc = 01 (load) or 10 (store). mem_req is never raised.
  - Otherwise register the bus outputs, set mem_req=1, clear the wait counter, go to WAIT.
- Byte enables: mem_be = ((1<<(1<<size))-1) << addr[LB-1:0].
- Store data: mem_wdata = the low 8·2^size bits of req_wdata replicated across all lanes. Loads drive mem_be as above and mem_wdata=0.
- WAIT, mem_ack=1: drop mem_req.
  - Load: extract the lane at offset addr[LB-1:0] of the latched size from mem_rdata. Sign-extend it to DATA_W, or zero-extend if req_unsigned=1. Register the result into rsp_rdata.
  - Store: rsp_rdata=0.
  - rsp_exc=00; go to RESP.
- WAIT, no ack, TIMEOUT≠0 and counter == TIMEOUT-1: drop mem_req, rsp_exc=11, rsp_rdata=0, go to RESP. Otherwise increment the counter.
- RESP: rsp_valid=1 for exactly this cycle; go to IDLE next edge. rsp_rdata and rsp_exc hold until the next response.
- mem_addr, mem_we, mem_be and mem_wdata are stable for the whole WAIT state.

## Timing
- Reset: state=IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_exc, and the counter. req_ready=1 from the first cycle after reset.
- Reset while in WAIT or RESP: the transaction is abandoned. mem_req is 0 after the edge and no rsp_valid is produced.
- Accept edge = T0.
  - Normal access: mem_req high from T0+1. An ack in cycle T0+k (k≥1) gives rsp_valid in cycle T0+k+1. Minimum latency is 2 cycles.
  - Address error: rsp_valid in T0+1.
  - Timeout: mem_req is high for exactly TIMEOUT cycles; rsp_valid follows in the next cycle.
- Throughput: one access per 3 cycles minimum. req_valid is ignored while req_ready=0.
- An ack arriving in the same cycle as the timeout count is treated as a successful ack (ack wins).
- mem_ack while mem_req=0 is ignored.

## Test plan
- DATA_W=32, load byte signed, addr=0x1003, mem_rdata=0x80_12_34_56, ack at T0+1 -> mem_be=1000, rsp_valid at T0+2, rsp_rdata=0xFFFFFF80, rsp_exc=00.
- DATA_W=64, unsigned half load, addr=0x06, mem_rdata=0xBEEF_0000_0000_0000 -> mem_be=0xC0, rsp_rdata=0x000000000000BEEF.
- DATA_W=32, store half, addr=0x2002, req_wdata=0x0000ABCD -> mem_addr=0x2000, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; rsp_rdata=0 after ack.
- Word load at addr=0x0001 -> no mem_req, rsp_valid at T0+1 with rsp_exc=01; store word at 0x0002 -> rsp_exc=10.
- TIMEOUT=4, mem_ack tied low -> mem_req high for exactly 4 cycles, then rsp_valid with rsp_exc=11. Repeat with ack in the 4th cycle -> rsp_exc=00.
- Reset asserted in the second WAIT cycle -> mem_req=0 and req_ready=1 after the edge, no rsp_valid. A following request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit bridging the MEM stage to a single-beat data-memory bus:
// byte-lane steering, alignment check, ack/timeout FSM, extended load response.
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_exc
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [DATA_W-1:0] low_mask(input logic [1:0] size);
    int nbits;
    nbits = 8 << size;
    if (nbits >= DATA_W) return '1;
    return (DATA_W'(1) << nbits) - DATA_W'(1);
  endfunction

  function automatic logic [NB-1:0] byte_enables(input logic [1:0] size, input logic [LB-1:0] off);
    logic [15:0] w;
    w = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return w[NB-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] lane, r;
    lane = d & low_mask(size);
    r    = '0;
    for (int i = 0; i < NB; i++)
      if ((i % (1 << size)) == 0) r = r | (lane << (8 * i));
    return r;
  endfunction

  // Shift the addressed lane down, then sign- or zero-fill above its MSB.
  function automatic logic [DATA_W-1:0] extend(input logic [1:0] size, input logic uns,
                                               input logic [LB-1:0] off, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] sh, m, top;
    sh  = d >> (8 * int'(off));
    m   = low_mask(size);
    top = (m >> 1) + DATA_W'(1);
    if (!uns && ((sh & top) != '0)) return (sh & m) | ~m;
    return sh & m;
  endfunction

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [LB-1:0]       r_off;
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [NB-1:0]       r_mem_be;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_exc;
  logic [2:0]          w_amask;
  logic                w_mis, w_tmo;
  logic [LB-1:0]       w_off;

  assign w_off   = req_addr[LB-1:0];
  assign w_amask = 3'((4'd1 << req_size) - 4'd1);
  assign w_mis   = ((req_addr[2:0] & w_amask) != 3'b0) || ((8 << req_size) > DATA_W);
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_mis ? RESP : WAIT;
      WAIT:    if (mem_ack || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_off       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_exc   <= 2'b00;
    end else begin
      r_rsp_valid <= (w_next == RESP);
      case (r_state)
        IDLE: if (req_valid) begin
          r_size <= req_size;
          r_uns  <= req_unsigned;
          r_off  <= w_off;
          r_cnt  <= '0;
          if (w_mis) begin
            r_rsp_exc   <= req_we ? 2'b10 : 2'b01;
            r_rsp_rdata <= '0;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= req_we;
            r_mem_addr  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            r_mem_be    <= byte_enables(req_size, w_off);
            r_mem_wdata <= req_we ? replicate(req_size, req_wdata) : '0;
          end
        end
        // An ack coinciding with the last timeout count still completes normally.
        WAIT: if (mem_ack) begin
          r_mem_req   <= 1'b0;
          r_rsp_exc   <= 2'b00;
          r_rsp_rdata <= r_mem_we ? '0 : extend(r_size, r_uns, r_off, mem_rdata);
        end else if (w_tmo) begin
          r_mem_req   <= 1'b0;
          r_rsp_exc   <= 2'b11;
          r_rsp_rdata <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_exc   = r_rsp_exc;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit (TIMEOUT=4) and a 64-bit instance share
// stimulus; directed cases plus random accesses against an arithmetic model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wide;
  logic        req_valid, req_we, req_uns, mem_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        a_ready, a_mreq, a_mwe, a_rvalid;
  logic [31:0] a_maddr, a_mwdata, a_rdata;
  logic [3:0]  a_be;
  logic [1:0]  a_exc;
  logic        b_ready, b_mreq, b_mwe, b_rvalid;
  logic [31:0] b_maddr;
  logic [63:0] b_mwdata, b_rdata;
  logic [7:0]  b_be;
  logic [1:0]  b_exc;

  logic        o_ready, o_mreq, o_mwe, o_rvalid;
  logic [63:0] o_addr, o_be, o_wdata, o_rdata;
  logic [1:0]  o_exc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~wide), .req_ready(a_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_be(a_be),
    .mem_wdata(a_mwdata), .mem_ack(mem_ack & ~wide), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_exc(a_exc)
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & wide), .req_ready(b_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_be(b_be),
    .mem_wdata(b_mwdata), .mem_ack(mem_ack & wide), .mem_rdata(mem_rdata),
    .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_exc(b_exc)
  );

  assign o_ready  = wide ? b_ready  : a_ready;
  assign o_mreq   = wide ? b_mreq   : a_mreq;
  assign o_mwe    = wide ? b_mwe    : a_mwe;
  assign o_rvalid = wide ? b_rvalid : a_rvalid;
  assign o_exc    = wide ? b_exc    : a_exc;
  assign o_addr   = wide ? {32'b0, b_maddr} : {32'b0, a_maddr};
  assign o_be     = wide ? {56'b0, b_be}    : {60'b0, a_be};
  assign o_wdata  = wide ? b_mwdata : {32'b0, a_mwdata};
  assign o_rdata  = wide ? b_rdata  : {32'b0, a_rdata};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mis(int dw, logic [1:0] size, logic [31:0] addr);
    return ((addr % (32'd1 << size)) != 0) || ((8 << size) > dw);
  endfunction

  function automatic logic [63:0] m_be(int dw, logic [1:0] size, logic [31:0] addr);
    return ((64'd1 << (1 << size)) - 64'd1) << (addr % (dw / 8));
  endfunction

  function automatic logic [63:0] m_rep(int dw, logic [1:0] size, logic [63:0] d);
    int nb;
    logic [63:0] v, pat;
    nb  = 8 << size;
    v   = (nb == 64) ? d : d % (64'd1 << nb);
    pat = 0;
    for (int i = 0; i < dw; i += nb) pat += 64'd1 << i;
    return v * pat;
  endfunction

  function automatic logic [63:0] m_load(int dw, logic [1:0] size, bit uns, logic [31:0] addr,
                                         logic [63:0] rdata);
    int nb, off;
    logic [63:0] lane;
    nb   = 8 << size;
    off  = int'(addr % (dw / 8));
    lane = rdata >> (8 * off);
    if (nb < 64) lane = lane % (64'd1 << nb);
    if (!uns && nb < dw && lane >= (64'd1 << (nb - 1))) lane = lane - (64'd1 << nb);
    if (dw == 32) lane = lane & 64'hFFFF_FFFF;
    return lane;
  endfunction

  // One complete access; ackk = cycle after accept in which ack is driven (0 = never).
  task automatic access(input bit wd, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wdata, input int ackk,
                        input logic [63:0] rdata, input string tag);
    int dw, to, nreq;
    bit err, acked;
    logic [1:0] exp_exc;
    logic [63:0] exp_rd;
    wide  = wd;
    dw    = wd ? 64 : 32;
    to    = wd ? 16 : 4;
    err   = m_mis(dw, size, addr);
    acked = (ackk >= 1) && (ackk <= to);
    nreq  = acked ? ackk : to;
    #1;
    chk({tag, " ready"}, o_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0; req_wdata = {$urandom, $urandom}; req_addr = $urandom;
    if (err) begin
      exp_exc = we ? 2'b10 : 2'b01;
      exp_rd  = 0;
      chk({tag, " err mem_req"}, o_mreq, 0);
    end else begin
      for (int k = 1; k <= nreq; k++) begin
        chk({tag, " mem_req"}, o_mreq, 1);
        chk({tag, " early rsp"}, o_rvalid, 0);
        chk({tag, " mem_addr"}, o_addr, {32'b0, addr & ~(32'(dw / 8) - 32'd1)});
        chk({tag, " mem_be"}, o_be, m_be(dw, size, addr));
        chk({tag, " mem_we"}, o_mwe, we);
        chk({tag, " mem_wdata"}, o_wdata, we ? m_rep(dw, size, wdata) : 64'd0);
        mem_ack   = (k == ackk);
        mem_rdata = (k == ackk) ? rdata : {$urandom, $urandom};
        @(posedge clk); #1;
        mem_ack = 0;
      end
      chk({tag, " mem_req drop"}, o_mreq, 0);
      exp_exc = acked ? 2'b00 : 2'b11;
      exp_rd  = (acked && !we) ? m_load(dw, size, uns, addr, rdata) : 64'd0;
    end
    chk({tag, " rsp_valid"}, o_rvalid, 1);
    chk({tag, " rsp_exc"}, o_exc, exp_exc);
    chk({tag, " rsp_rdata"}, o_rdata, exp_rd);
    @(posedge clk); #1;
    chk({tag, " rsp pulse"}, o_rvalid, 0);
    chk({tag, " rsp_exc hold"}, o_exc, exp_exc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    bit          wd;
    reset = 1; wide = 0; req_valid = 0; req_we = 0; req_uns = 0; mem_ack = 0;
    req_size = 0; req_addr = 0; req_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst a ready", a_ready, 1);
    chk("rst a outs", {a_mreq, a_mwe, a_rvalid, a_exc, a_be}, 0);
    chk("rst a data", {a_maddr, a_mwdata, a_rdata}, 0);
    chk("rst b ready", b_ready, 1);
    chk("rst b outs", {b_mreq, b_mwe, b_rvalid, b_exc, b_be}, 0);
    chk("rst b data", {b_maddr, b_mwdata ^ b_rdata}, 0);

    access(0, 0, 2'd0, 0, 32'h1003, 0, 1, 64'h8012_3456, "lb");
    chk("lb const", o_rdata, 64'hFFFF_FF80);
    chk("lb be const", o_be, 64'h8);
    access(1, 0, 2'd1, 1, 32'h6, 0, 1, 64'hBEEF_0000_0000_0000, "lhu64");
    chk("lhu64 const", o_rdata, 64'hBEEF);
    chk("lhu64 be const", o_be, 64'hC0);
    access(0, 1, 2'd1, 0, 32'h2002, 64'h0000_ABCD, 2, 0, "sh");
    chk("sh wdata const", o_wdata, 64'hABCD_ABCD);
    chk("sh addr const", o_addr, 64'h2000);
    chk("sh be const", o_be, 64'hC);
    access(0, 0, 2'd2, 0, 32'h0001, 0, 1, 0, "lw mis");
    access(0, 1, 2'd2, 0, 32'h0002, 64'h1234, 1, 0, "sw mis");
    access(0, 0, 2'd3, 0, 32'h0000, 0, 1, 0, "ld on 32");
    access(0, 0, 2'd2, 0, 32'h0100, 0, 0, 64'h55, "timeout");
    access(0, 0, 2'd2, 0, 32'h0104, 0, 4, 64'h8765_4321, "ack at 4");
    access(1, 0, 2'd3, 0, 32'h18, 0, 3, 64'hF123_4567_89AB_CDEF, "ld64");
    access(1, 1, 2'd2, 0, 32'h1C, 64'hDEAD_BEEF, 1, 0, "sw64");

    // Ack while idle must not start anything.
    wide = 0; mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("idle ack rsp", a_rvalid, 0);
    chk("idle ack req", a_mreq, 0);

    // Reset during the second WAIT cycle abandons the access.
    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("rstwait pre req", a_mreq, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rstwait mem_req", a_mreq, 0);
    chk("rstwait ready", a_ready, 1);
    chk("rstwait rsp", a_rvalid, 0);
    @(posedge clk); #1;
    chk("rstwait no rsp", a_rvalid, 0);
    access(0, 0, 2'd1, 0, 32'h42, 0, 1, 64'h9ABC_0000, "after rst");

    for (int n = 0; n < 60; n++) begin
      wd = 1'($urandom);
      sz = 2'($urandom);
      ad = $urandom;
      if (($urandom % 4) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      access(wd, 1'($urandom), sz, 1'($urandom), ad, {$urandom, $urandom},
             wd ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 5)),
             {$urandom, $urandom}, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
